// File: rtl/dmem_arb_pkg.sv
// dmem_arbiter shared types: FSM state, AddrMode codes, index width helper.
// Build option DMEM_ARB_ROUND_ROBIN_EN selects round-robin grant order.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam int ADDRMODE_W = 3;

  localparam logic [ADDRMODE_W-1:0] AM_LB  = 3'b000;
  localparam logic [ADDRMODE_W-1:0] AM_LH  = 3'b001;
  localparam logic [ADDRMODE_W-1:0] AM_LW  = 3'b010;
  localparam logic [ADDRMODE_W-1:0] AM_LBU = 3'b100;
  localparam logic [ADDRMODE_W-1:0] AM_LHU = 3'b101;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_picker.sv
// arb_picker: combinational grant select for dmem_arbiter.
// DMEM_ARB_ROUND_ROBIN_EN: round-robin from last+1; else lowest index wins.
module arb_picker
  import dmem_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  int          j;
  logic [IW-1:0] jj;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    jj  = '0;
    for (int i = 1; i <= N; i++) begin
      j  = (int'(last) + i) % N;
      jj = IW'(j);
      if (!any && req[jj]) begin
        gnt[jj] = 1'b1;
        idx     = jj;
        any     = 1'b1;
      end
    end
  end
`else
  logic unused_last;
  assign unused_last = ^last;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[i]) begin
        gnt[i] = 1'b1;
        idx    = IW'(i);
        any    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-ported data memory among NUM_REQ requesters.
// Grant order set by DMEM_ARB_ROUND_ROBIN_EN (round-robin) or fixed priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ-1:0]                    req_we,
  input  logic [NUM_REQ-1:0][ADDRMODE_W-1:0]    req_addrmode,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]                    rsp_valid,
  output logic [DATA_WIDTH-1:0]                 rsp_rdata,
  output logic                                  mem_req,
  output logic                                  mem_we,
  output logic [ADDRMODE_W-1:0]                 mem_addrmode,
  output logic [ADDR_WIDTH-1:0]                 mem_addr,
  output logic [DATA_WIDTH-1:0]                 mem_wdata,
  input  logic [DATA_WIDTH-1:0]                 mem_rdata
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = $clog2(MEM_LATENCY + 1);

  state_t              state;
  logic [IW-1:0]       last_grant;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [CW-1:0]       cnt;

  logic [NUM_REQ-1:0]  pick_oh;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;
  logic                open;
  logic                accept;

  arb_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req  (req_valid),
    .last (last_grant),
    .gnt  (pick_oh),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Requests are only looked at in IDLE and RESP; RESP allows back-to-back.
  assign open      = (state == IDLE) || (state == RESP);
  assign accept    = open && pick_any;
  assign req_ready = open ? pick_oh : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= IW'(NUM_REQ - 1);
      gnt_q        <= '0;
      cnt          <= '0;
      rsp_valid    <= '0;
      rsp_rdata    <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addrmode <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      mem_req   <= 1'b0;
      rsp_valid <= '0;
      unique case (state)
        IDLE, RESP: begin
          if (accept) begin
            state        <= ISSUE;
            mem_req      <= 1'b1;
            mem_we       <= req_we[pick_idx];
            mem_addrmode <= req_addrmode[pick_idx];
            mem_addr     <= req_addr[pick_idx];
            mem_wdata    <= req_wdata[pick_idx];
            gnt_q        <= pick_oh;
            last_grant   <= pick_idx;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          cnt   <= CW'(MEM_LATENCY);
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            rsp_rdata <= mem_we ? '0 : mem_rdata;
            rsp_valid <= gnt_q;
            state     <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_hs
    a_hold: assert property (
      @(posedge clk) disable iff (rst)
      req_valid[i] && !req_ready[i] |=> req_valid[i]
    );
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: per-cycle vector table on an L=1 arbiter,
// plus a hand-written latency sequence on an L=3 instance.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       valid3;
  logic [1:0]       req_we;
  logic [1:0][2:0]  req_addrmode;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [31:0]      mem_rdata;
  logic [31:0]      mrd3;

  logic [1:0]  rdy, rsp, rdy3, rsp3;
  logic [31:0] rdata, maddr, mwd, rdata3, maddr3, mwd3;
  logic        mreq, mwe, mreq3, mwe3;
  logic [2:0]  mam, mam3;

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(rdy),
    .req_we(req_we), .req_addrmode(req_addrmode),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp), .rsp_rdata(rdata),
    .mem_req(mreq), .mem_we(mwe), .mem_addrmode(mam),
    .mem_addr(maddr), .mem_wdata(mwd), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(
    .NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3)
  ) u3 (
    .clk(clk), .rst(rst),
    .req_valid(valid3), .req_ready(rdy3),
    .req_we(req_we), .req_addrmode(req_addrmode),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp3), .rsp_rdata(rdata3),
    .mem_req(mreq3), .mem_we(mwe3), .mem_addrmode(mam3),
    .mem_addr(maddr3), .mem_wdata(mwd3), .mem_rdata(mrd3)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  v;
    logic [1:0]  we;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] wd1;
    logic [31:0] mrd;
    logic [1:0]  erdy;
    logic        emreq;
    logic [31:0] eaddr;
    logic        ewe;
    logic [31:0] ewd;
    logic [2:0]  eam;
    logic [1:0]  ersp;
    logic [31:0] erd;
  } vec_t;

  vec_t tbl[$];

  localparam logic [2:0] W = AM_LW;
  localparam logic [2:0] H = AM_LHU;

  function automatic vec_t mk(
    input logic rs, input logic [1:0] v, input logic [1:0] we,
    input logic [31:0] a0, input logic [31:0] a1,
    input logic [31:0] wd1, input logic [31:0] mrd,
    input logic [1:0] erdy, input logic emreq,
    input logic [31:0] eaddr, input logic ewe,
    input logic [31:0] ewd, input logic [2:0] eam,
    input logic [1:0] ersp, input logic [31:0] erd);
    vec_t t;
    t.rst = rs; t.v = v; t.we = we; t.a0 = a0; t.a1 = a1;
    t.wd1 = wd1; t.mrd = mrd; t.erdy = erdy; t.emreq = emreq;
    t.eaddr = eaddr; t.ewe = ewe; t.ewd = ewd; t.eam = eam;
    t.ersp = ersp; t.erd = erd;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input int n);
    @(negedge clk);
    rst          = t.rst;
    req_valid    = t.v;
    req_we       = t.we;
    req_addr[0]  = t.a0;
    req_addr[1]  = t.a1;
    req_wdata[1] = t.wd1;
    mem_rdata    = t.mrd;
    #1;
    chk($sformatf("row%0d ready", n), 32'(rdy), 32'(t.erdy));
    chk($sformatf("row%0d mem_req", n), 32'(mreq), 32'(t.emreq));
    if (t.emreq) begin
      chk($sformatf("row%0d mem_addr", n), maddr, t.eaddr);
      chk($sformatf("row%0d mem_we", n), 32'(mwe), 32'(t.ewe));
      chk($sformatf("row%0d mem_wdata", n), mwd, t.ewd);
      chk($sformatf("row%0d mem_am", n), 32'(mam), 32'(t.eam));
    end
    chk($sformatf("row%0d rsp_valid", n), 32'(rsp), 32'(t.ersp));
    if (t.ersp != 2'b00)
      chk($sformatf("row%0d rsp_rdata", n), rdata, t.erd);
  endtask

  initial begin
    // single load, L=1
    tbl.push_back(mk(0,2'b01,2'b00,32'h10,0,0,0, 2'b01,0,0,0,0,0, 2'b00,0));
    tbl.push_back(mk(0,2'b00,2'b00,32'h10,0,0,0, 2'b00,1,32'h10,0,0,W, 2'b00,0));
    tbl.push_back(mk(0,2'b00,2'b00,0,0,0,32'hDEADBEEF, 2'b00,0,0,0,0,0, 2'b00,0));
    tbl.push_back(mk(0,2'b00,2'b00,0,0,0,0, 2'b00,0,0,0,0,0, 2'b01,32'hDEADBEEF));
    tbl.push_back(mk(0,2'b00,2'b00,0,0,0,0, 2'b00,0,0,0,0,0, 2'b00,0));
    // simultaneous request, back-to-back in RESP
    tbl.push_back(mk(0,2'b11,2'b00,32'h100,32'h200,0,0, 2'b01,0,0,0,0,0, 2'b00,0));
    tbl.push_back(mk(0,2'b10,2'b00,32'h100,32'h200,0,0, 2'b00,1,32'h100,0,0,W, 2'b00,0));
    tbl.push_back(mk(0,2'b10,2'b00,32'h100,32'h200,0,32'hA0A0A0A0, 2'b00,0,0,0,0,0, 2'b00,0));
    tbl.push_back(mk(0,2'b10,2'b00,32'h100,32'h200,0,0, 2'b10,0,0,0,0,0, 2'b01,32'hA0A0A0A0));
    tbl.push_back(mk(0,2'b00,2'b00,0,0,0,0, 2'b00,1,32'h200,0,0,H, 2'b00,0));
    tbl.push_back(mk(0,2'b00,2'b00,0,0,0,32'hB1B1B1B1, 2'b00,0,0,0,0,0, 2'b00,0));
    tbl.push_back(mk(0,2'b00,2'b00,0,0,0,0, 2'b00,0,0,0,0,0, 2'b10,32'hB1B1B1B1));
    tbl.push_back(mk(0,2'b00,2'b00,0,0,0,0, 2'b00,0,0,0,0,0, 2'b00,0));
    // persistent requests from both ports
    tbl.push_back(mk(0,2'b11,2'b00,32'h30,32'h40,0,0, 2'b01,0,0,0,0,0, 2'b00,0));
    tbl.push_back(mk(0,2'b11,2'b00,32'h30,32'h40,0,0, 2'b00,1,32'h30,0,0,W, 2'b00,0));
    tbl.push_back(mk(0,2'b11,2'b00,32'h30,32'h40,0,32'h11, 2'b00,0,0,0,0,0, 2'b00,0));
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    tbl.push_back(mk(0,2'b11,2'b00,32'h30,32'h40,0,0, 2'b10,0,0,0,0,0, 2'b01,32'h11));
    tbl.push_back(mk(0,2'b11,2'b00,32'h30,32'h40,0,0, 2'b00,1,32'h40,0,0,H, 2'b00,0));
    tbl.push_back(mk(0,2'b11,2'b00,32'h30,32'h40,0,32'h22, 2'b00,0,0,0,0,0, 2'b00,0));
    tbl.push_back(mk(0,2'b11,2'b00,32'h30,32'h40,0,0, 2'b01,0,0,0,0,0, 2'b10,32'h22));
`else
    tbl.push_back(mk(0,2'b11,2'b00,32'h30,32'h40,0,0, 2'b01,0,0,0,0,0, 2'b01,32'h11));
    tbl.push_back(mk(0,2'b11,2'b00,32'h30,32'h40,0,0, 2'b00,1,32'h30,0,0,W, 2'b00,0));
    tbl.push_back(mk(0,2'b11,2'b00,32'h30,32'h40,0,32'h22, 2'b00,0,0,0,0,0, 2'b00,0));
    tbl.push_back(mk(0,2'b11,2'b00,32'h30,32'h40,0,0, 2'b01,0,0,0,0,0, 2'b01,32'h22));
`endif
    tbl.push_back(mk(0,2'b10,2'b00,32'h30,32'h40,0,0, 2'b00,1,32'h30,0,0,W, 2'b00,0));
    tbl.push_back(mk(0,2'b10,2'b00,32'h30,32'h40,0,32'h33, 2'b00,0,0,0,0,0, 2'b00,0));
    tbl.push_back(mk(0,2'b10,2'b00,32'h30,32'h40,0,0, 2'b10,0,0,0,0,0, 2'b01,32'h33));
    tbl.push_back(mk(0,2'b00,2'b00,0,32'h40,0,0, 2'b00,1,32'h40,0,0,H, 2'b00,0));
    tbl.push_back(mk(0,2'b00,2'b00,0,0,0,32'h44, 2'b00,0,0,0,0,0, 2'b00,0));
    tbl.push_back(mk(0,2'b00,2'b00,0,0,0,0, 2'b00,0,0,0,0,0, 2'b10,32'h44));
    // store from port 1
    tbl.push_back(mk(0,2'b10,2'b10,0,32'h20,32'h12345678,0, 2'b10,0,0,0,0,0, 2'b00,0));
    tbl.push_back(mk(0,2'b00,2'b00,0,32'h20,32'h12345678,0, 2'b00,1,32'h20,1,32'h12345678,H, 2'b00,0));
    tbl.push_back(mk(0,2'b00,2'b00,0,0,0,32'hFFFFFFFF, 2'b00,0,0,0,0,0, 2'b00,0));
    tbl.push_back(mk(0,2'b00,2'b00,0,0,0,0, 2'b00,0,0,0,0,0, 2'b10,32'h0));
    // reset during WAIT, then a normal access
    tbl.push_back(mk(0,2'b01,2'b00,32'h60,0,0,0, 2'b01,0,0,0,0,0, 2'b00,0));
    tbl.push_back(mk(0,2'b00,2'b00,32'h60,0,0,0, 2'b00,1,32'h60,0,0,W, 2'b00,0));
    tbl.push_back(mk(1,2'b00,2'b00,0,0,0,32'h77777777, 2'b00,0,0,0,0,0, 2'b00,0));
    tbl.push_back(mk(0,2'b00,2'b00,0,0,0,32'h77777777, 2'b00,0,0,0,0,0, 2'b00,0));
    tbl.push_back(mk(0,2'b00,2'b00,0,0,0,0, 2'b00,0,0,0,0,0, 2'b00,0));
    tbl.push_back(mk(0,2'b01,2'b00,32'h64,0,0,0, 2'b01,0,0,0,0,0, 2'b00,0));
    tbl.push_back(mk(0,2'b00,2'b00,32'h64,0,0,0, 2'b00,1,32'h64,0,0,W, 2'b00,0));
    tbl.push_back(mk(0,2'b00,2'b00,0,0,0,32'h64646464, 2'b00,0,0,0,0,0, 2'b00,0));
    tbl.push_back(mk(0,2'b00,2'b00,0,0,0,0, 2'b00,0,0,0,0,0, 2'b01,32'h64646464));

    rst          = 1'b1;
    req_valid    = '0;
    valid3       = '0;
    req_we       = '0;
    req_addrmode = {H, W};
    req_addr     = '0;
    req_wdata    = '0;
    mem_rdata    = '0;
    mrd3         = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset ready", 32'(rdy), 32'h0);
    chk("reset mem_req", 32'(mreq), 32'h0);
    chk("reset rsp_valid", 32'(rsp), 32'h0);
    chk("reset rsp_rdata", rdata, 32'h0);
    chk("reset mem_addr", maddr, 32'h0);
    chk("reset mem_wdata", mwd, 32'h0);
    chk("reset mem_we", 32'(mwe), 32'h0);
    chk("reset u3 mem_req", 32'(mreq3), 32'h0);
    chk("reset u3 rsp_valid", 32'(rsp3), 32'h0);
    rst = 1'b0;

    foreach (tbl[i]) apply(tbl[i], i);

    // L=3 load: rsp_valid exactly 5 cycles after accept
    @(negedge clk);
    req_we      = '0;
    req_addr[0] = 32'h50;
    valid3      = 2'b01;
    #1;
    chk("l3 ready", 32'(rdy3), 32'h1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      valid3 = '0;
      mrd3   = (k == 4) ? 32'hCAFEF00D : 32'h0;
      #1;
      chk($sformatf("l3 c%0d mem_req", k), 32'(mreq3), 32'(k == 1));
      chk($sformatf("l3 c%0d rsp_valid", k), 32'(rsp3),
          (k == 5) ? 32'h1 : 32'h0);
      if (k == 1) chk("l3 mem_addr", maddr3, 32'h50);
      if (k == 5) chk("l3 rsp_rdata", rdata3, 32'hCAFEF00D);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
